// File: rtl/hazard_mem_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / data-memory controller.
package hazard_pkg;

    // ALU operand source select: register file, write-back result, or MEM-stage result.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // ResultSrc encodings of the instruction in E.
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // Data-memory access sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } mem_state_t;

    // Pick the forwarding source for one source register; the younger M result wins over W.
    function automatic fwd_sel_t fwd_select(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        fwd_sel_t sel;
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FWD_MEM;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_mem_ctrl_if.sv
// Data-memory request/grant/completion handshake between the pipeline controller and memory.
interface hazard_mem_ctrl_if;

    logic dmem_req;
    logic dmem_gnt;
    logic dmem_rvalid;

    // Controller side: issues the request, observes grant and completion.
    modport master (
        output dmem_req,
        input  dmem_gnt,
        input  dmem_rvalid
    );

    // Memory side: observes the request, returns grant and completion.
    modport slave (
        input  dmem_req,
        output dmem_gnt,
        output dmem_rvalid
    );

endinterface

// File: rtl/hazard_mem_ctrl_forward_unit.sv
// Combinational operand forwarding for both ALU sources of the instruction in E.
module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output fwd_sel_t   fwd_a,
    output fwd_sel_t   fwd_b
);

    // Resolve each operand independently with M taking priority over W.
    always_comb begin
        fwd_a = fwd_select(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
        fwd_b = fwd_select(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    end

endmodule

// File: rtl/hazard_mem_ctrl.sv
// Central pipeline controller: forwarding, load-use interlock, branch flush and
// MEM-stage data-memory sequencing with a timeout that force-completes hung accesses.
module hazard_mem_ctrl
    import hazard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [1:0] ResultSrcE,
    input  logic       PCSrcE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemReqM,
    hazard_mem_ctrl_if.master mem_bus,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       MemErr
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Index (issue cycle = 0) of the last cycle an access may stay outstanding.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_t       state_r;
    mem_state_t       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             busy_s;
    logic             timeout_s;
    logic             req_s;
    logic             release_s;
    logic             memstall_s;
    logic             lw_stall_s;
    fwd_sel_t         fwd_a_s;
    fwd_sel_t         fwd_b_s;

    forward_unit u_forward_unit (
        .Rs1E      (Rs1E),
        .Rs2E      (Rs2E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .fwd_a     (fwd_a_s),
        .fwd_b     (fwd_b_s)
    );

    // cnt_r counts REQ/WAIT cycles already spent, so cnt_r + 1 is the current cycle's
    // index within the access (issue cycle in IDLE = 0); time out on the last allowed one.
    always_comb begin
        cnt_inc_s = cnt_r + CNT_W'(1);
        busy_s    = (state_r == REQ) || (state_r == WAIT);
        timeout_s = busy_s && (cnt_inc_s == TIMEOUT_LAST);
        release_s = (state_r == WAIT) && mem_bus.dmem_rvalid;
    end

    // Next-state, request and counter update for the memory access sequencer.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = CNT_W'(0);
        req_s       = 1'b0;
        case (state_r)
            IDLE: begin
                req_s = MemReqM;
                if (MemReqM && mem_bus.dmem_gnt) begin
                    state_nxt_s = WAIT;
                end else if (MemReqM) begin
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                req_s = 1'b1;
                if (timeout_s) begin
                    state_nxt_s = IDLE;
                end else if (mem_bus.dmem_gnt) begin
                    state_nxt_s = WAIT;
                    cnt_nxt_s   = cnt_inc_s;
                end else begin
                    state_nxt_s = REQ;
                    cnt_nxt_s   = cnt_inc_s;
                end
            end
            WAIT: begin
                req_s = 1'b0;
                if (timeout_s) begin
                    state_nxt_s = IDLE;
                end else if (mem_bus.dmem_rvalid) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT;
                    cnt_nxt_s   = cnt_inc_s;
                end
            end
            default: begin
                // Unreachable encoding: fall back to a safe idle with no request.
                req_s       = 1'b0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Sequencer state and timeout counter; reset aborts any in-flight access at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= CNT_W'(0);
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Memory stall holds until completion or timeout; load-use needs a loaded RdE read in D.
    always_comb begin
        memstall_s = MemReqM && !release_s && !timeout_s;
        lw_stall_s = (ResultSrcE == RES_MEM) && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));
    end

    // Stall/flush priority: a memory stall freezes F..M and bubbles WB, deferring everything else.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (reset) begin
            StallF = 1'b0;
            StallD = 1'b0;
        end else if (memstall_s) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = lw_stall_s;
            StallD = lw_stall_s;
            FlushE = lw_stall_s || PCSrcE;
            FlushD = PCSrcE;
        end
    end

    // Remaining outputs are forced low while reset is held.
    always_comb begin
        if (reset) begin
            mem_bus.dmem_req = 1'b0;
            MemErr           = 1'b0;
            ForwardAE        = 2'b00;
            ForwardBE        = 2'b00;
        end else begin
            mem_bus.dmem_req = req_s;
            MemErr           = timeout_s;
            ForwardAE        = fwd_a_s;
            ForwardBE        = fwd_b_s;
        end
    end

endmodule

// File: tb/tb_hazard_mem_ctrl.sv
// Self-checking bench for hazard_mem_ctrl: expected control words and forwarding selects
// are queued when stimulus is applied and popped when the outputs are sampled.
module tb_hazard_mem_ctrl;
    import hazard_pkg::*;

    localparam int TO = 8;

    // Control word: {dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr}
    localparam logic [8:0] C_IDLE      = 9'b0_0000_000_0;
    localparam logic [8:0] C_STALL_REQ = 9'b1_1111_001_0;
    localparam logic [8:0] C_STALL     = 9'b0_1111_001_0;
    localparam logic [8:0] C_LW        = 9'b0_1100_010_0;
    localparam logic [8:0] C_BR        = 9'b0_0000_110_0;
    localparam logic [8:0] C_LW_BR     = 9'b0_1100_110_0;
    localparam logic [8:0] C_ERR       = 9'b0_0000_000_1;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, RegWriteM, RegWriteW, MemReqM;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
    logic [1:0] ForwardAE, ForwardBE;
    logic [8:0] ctl;

    logic [8:0] ctl_q[$];
    logic [3:0] fwd_q[$];
    int         n_cmp  = 0;
    int         n_fail = 0;

    hazard_mem_ctrl_if mem_bus ();

    hazard_mem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .ResultSrcE (ResultSrcE),
        .PCSrcE     (PCSrcE),
        .RdM        (RdM),
        .RdW        (RdW),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .MemReqM    (MemReqM),
        .mem_bus    (mem_bus.master),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .FlushW     (FlushW),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .MemErr     (MemErr)
    );

    always #5 clk = ~clk;

    assign ctl = {mem_bus.dmem_req, StallF, StallD, StallE, StallM,
                  FlushD, FlushE, FlushW, MemErr};

    // Quiet pipeline: no hazards, no forwarding, no memory activity.
    task automatic quiet();
        Rs1D = 5'd1; Rs2D = 5'd2; Rs1E = 5'd3; Rs2E = 5'd4; RdE = 5'd0;
        RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        ResultSrcE = RES_ALU; PCSrcE = 1'b0; MemReqM = 1'b0;
        mem_bus.dmem_gnt = 1'b0; mem_bus.dmem_rvalid = 1'b0;
    endtask

    // Stimulus vector {MemReqM, gnt, rvalid, PCSrcE, load-use in E}.
    task automatic apply(input logic [4:0] s);
        MemReqM             = s[4];
        mem_bus.dmem_gnt    = s[3];
        mem_bus.dmem_rvalid = s[2];
        PCSrcE              = s[1];
        ResultSrcE          = s[0] ? RES_MEM : RES_ALU;
        RdE                 = s[0] ? 5'd7 : 5'd0;
        Rs2D                = s[0] ? 5'd7 : 5'd2;
    endtask

    task automatic test_reset();
        logic [8:0] exp;
        reset = 1'b1;
        quiet();
        MemReqM = 1'b1; mem_bus.dmem_gnt = 1'b1; PCSrcE = 1'b1;
        RdM = 5'd5; RegWriteM = 1'b1; Rs1E = 5'd5; Rs2E = 5'd5;
        ResultSrcE = RES_MEM; RdE = 5'd7; Rs1D = 5'd7;
        ctl_q.push_back(C_IDLE);
        fwd_q.push_back(4'b0000);
        #2;
        exp = ctl_q.pop_front();
        n_cmp++;
        if (ctl !== exp) begin
            n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl, exp);
        end
        n_cmp++;
        if ({ForwardAE, ForwardBE} !== fwd_q[0]) begin
            n_fail++; $display("FAIL reset_fwd: got %b expected %b", {ForwardAE, ForwardBE}, fwd_q[0]);
        end
        void'(fwd_q.pop_front());
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        quiet();
        ctl_q.push_back(C_IDLE);
        #4;
        exp = ctl_q.pop_front();
        n_cmp++;
        if (ctl !== exp) begin
            n_fail++; $display("FAIL reset_release: got %b expected %b", ctl, exp);
        end
    endtask

    task automatic test_forward();
        // {RdM, WM, RdW, WW, Rs1E, Rs2E, expA, expB}
        logic [33:0] tab [7] = '{
            {5'd5,  1'b1, 5'd5,  1'b1, 5'd5,  5'd5,  2'b10, 2'b10},
            {5'd0,  1'b1, 5'd0,  1'b1, 5'd0,  5'd0,  2'b00, 2'b00},
            {5'd5,  1'b0, 5'd5,  1'b1, 5'd5,  5'd3,  2'b01, 2'b00},
            {5'd7,  1'b1, 5'd9,  1'b1, 5'd9,  5'd7,  2'b01, 2'b10},
            {5'd12, 1'b1, 5'd12, 1'b0, 5'd12, 5'd12, 2'b10, 2'b10},
            {5'd3,  1'b0, 5'd3,  1'b0, 5'd3,  5'd3,  2'b00, 2'b00},
            {5'd31, 1'b1, 5'd0,  1'b1, 5'd31, 5'd0,  2'b10, 2'b00}
        };
        logic [3:0] exp;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            {RdM, RegWriteM, RdW, RegWriteW, Rs1E, Rs2E} = tab[i][33:4];
            fwd_q.push_back(tab[i][3:0]);
            #4;
            exp = fwd_q.pop_front();
            n_cmp++;
            if ({ForwardAE, ForwardBE} !== exp) begin
                n_fail++;
                $display("FAIL forward[%0d]: got A=%b B=%b expected A=%b B=%b",
                         i, ForwardAE, ForwardBE, exp[3:2], exp[1:0]);
            end
        end
        quiet();
    endtask

    task automatic test_load_use();
        logic [8:0] exp;
        logic [8:0] exp_tab [4] = '{C_LW, C_IDLE, C_IDLE, C_IDLE};
        for (int c = 0; c < 4; c++) ctl_q.push_back(exp_tab[c]);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            quiet();
            case (c)
                0: apply(5'b00001);
                2: begin ResultSrcE = RES_MEM; RdE = 5'd0; Rs1D = 5'd0; end
                3: begin ResultSrcE = RES_PC4; RdE = 5'd9; Rs1D = 5'd9; end
                default: quiet();
            endcase
            #4;
            exp = ctl_q.pop_front();
            n_cmp++;
            if (ctl !== exp) begin
                n_fail++; $display("FAIL load_use c%0d: got %b expected %b", c, ctl, exp);
            end
        end
        quiet();
    endtask

    task automatic test_mem_gnt_first();
        logic [8:0] exp;
        logic [4:0] stim    [7] = '{5'b11000, 5'b10000, 5'b10000, 5'b10100,
                                    5'b11000, 5'b10100, 5'b00000};
        logic [8:0] exp_tab [7] = '{C_STALL_REQ, C_STALL, C_STALL, C_IDLE,
                                    C_STALL_REQ, C_IDLE, C_IDLE};
        for (int c = 0; c < 7; c++) ctl_q.push_back(exp_tab[c]);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            apply(stim[c]);
            #4;
            exp = ctl_q.pop_front();
            n_cmp++;
            if (ctl !== exp) begin
                n_fail++; $display("FAIL mem_gnt_first c%0d: got %b expected %b", c, ctl, exp);
            end
        end
        quiet();
    endtask

    task automatic test_mem_gnt_late();
        logic [8:0] exp;
        logic [4:0] stim    [5] = '{5'b10000, 5'b10100, 5'b11000, 5'b10100, 5'b00000};
        logic [8:0] exp_tab [5] = '{C_STALL_REQ, C_STALL_REQ, C_STALL_REQ, C_IDLE, C_IDLE};
        for (int c = 0; c < 5; c++) ctl_q.push_back(exp_tab[c]);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            apply(stim[c]);
            #4;
            exp = ctl_q.pop_front();
            n_cmp++;
            if (ctl !== exp) begin
                n_fail++; $display("FAIL mem_gnt_late c%0d: got %b expected %b", c, ctl, exp);
            end
        end
        quiet();
    endtask

    task automatic test_branch_in_stall();
        logic [8:0] exp;
        logic [4:0] stim    [5] = '{5'b11010, 5'b10011, 5'b10111, 5'b00010, 5'b00000};
        logic [8:0] exp_tab [5] = '{C_STALL_REQ, C_STALL, C_LW_BR, C_BR, C_IDLE};
        for (int c = 0; c < 5; c++) ctl_q.push_back(exp_tab[c]);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            apply(stim[c]);
            #4;
            exp = ctl_q.pop_front();
            n_cmp++;
            if (ctl !== exp) begin
                n_fail++; $display("FAIL branch_in_stall c%0d: got %b expected %b", c, ctl, exp);
            end
        end
        quiet();
    endtask

    task automatic test_timeout();
        logic [8:0] exp;
        logic [4:0] stim    [13] = '{5'b11000, 5'b10000, 5'b10000, 5'b10000, 5'b10000,
                                     5'b10000, 5'b10000, 5'b10000, 5'b00100, 5'b10000,
                                     5'b11000, 5'b10100, 5'b00000};
        logic [8:0] exp_tab [13] = '{C_STALL_REQ, C_STALL, C_STALL, C_STALL, C_STALL,
                                     C_STALL, C_STALL, C_ERR, C_IDLE, C_STALL_REQ,
                                     C_STALL_REQ, C_IDLE, C_IDLE};
        for (int c = 0; c < 13; c++) ctl_q.push_back(exp_tab[c]);
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            apply(stim[c]);
            #4;
            exp = ctl_q.pop_front();
            n_cmp++;
            if (ctl !== exp) begin
                n_fail++; $display("FAIL timeout c%0d: got %b expected %b", c, ctl, exp);
            end
        end
        quiet();
    endtask

    task automatic test_reset_mid_access();
        logic [8:0] exp;
        logic [3:0] fexp;
        logic [4:0] stim    [6] = '{5'b11000, 5'b10000, 5'b10000, 5'b10000, 5'b11000, 5'b10100};
        logic [8:0] exp_tab [6] = '{C_STALL_REQ, C_STALL, C_IDLE, C_STALL_REQ, C_STALL_REQ, C_IDLE};
        for (int c = 0; c < 6; c++) ctl_q.push_back(exp_tab[c]);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            apply(stim[c]);
            RdM = 5'd5; RegWriteM = 1'b1; Rs1E = 5'd5;
            reset = (c == 2) ? 1'b1 : 1'b0;
            if (c == 2) fwd_q.push_back(4'b0000);
            else if (c == 3) fwd_q.push_back(4'b1000);
            #1;
            exp = ctl_q.pop_front();
            n_cmp++;
            if (ctl !== exp) begin
                n_fail++; $display("FAIL reset_mid_access c%0d: got %b expected %b", c, ctl, exp);
            end
            if (c == 2 || c == 3) begin
                fexp = fwd_q.pop_front();
                n_cmp++;
                if ({ForwardAE, ForwardBE} !== fexp) begin
                    n_fail++;
                    $display("FAIL reset_mid_fwd c%0d: got %b expected %b", c, {ForwardAE, ForwardBE}, fexp);
                end
            end
        end
        @(negedge clk);
        quiet();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_mem_gnt_first();
        test_mem_gnt_late();
        test_branch_in_stall();
        test_timeout();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_mem_ctrl.md
Name: hazard_mem_ctrl

Overview:
Central pipeline controller for the 5-stage RISC-V core. It generates forwarding selects, load-use interlock and branch flushes, and sequences data-memory accesses in the MEM stage through a req/gnt/rvalid handshake. While an access is outstanding it freezes the F/D/E/M stages and injects bubbles into the MEM/WB register. It is the only block allowed to drive stall or flush controls for any pipeline register.

Parameters:
TIMEOUT_CYCLES, 64, cycles an access may stay outstanding (REQ+WAIT) before it is force-completed with MemErr.
CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter (derived; do not override).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
Rs1D, Rs2D  in  5 each  source registers of the instruction in D
Rs1E, Rs2E, RdE  in  5 each  source and destination registers of the instruction in E
ResultSrcE  in  2  result select in E; 01 = load
PCSrcE  in  1  taken branch/jump resolved in E
RdM, RdW  in  5 each  destination registers in M and W
RegWriteM, RegWriteW  in  1 each  register-write enables in M and W
MemReqM  in  1  M-stage instruction is a load or store
dmem_req  out  1  data-memory request
dmem_gnt  in  1  memory accepted the request
dmem_rvalid  in  1  memory completed the access (read data valid, or store done)
StallF, StallD, StallE, StallM  out  1 each  hold enables for PC, IF/ID, ID/EX and EX/MEM
FlushD, FlushE, FlushW  out  1 each  synchronous clears of IF/ID, ID/EX and MEM/WB
ForwardAE, ForwardBE  out  2 each  ALU operand source selects
MemErr  out  1  one-cycle pulse when an access times out

Behaviour:
- Reset: FSM goes to IDLE and the counter to 0. While reset is high, all outputs are 0, including dmem_req and MemErr.
- Forwarding (combinational), shown for A; B is identical using Rs2E:
  - if RegWriteM & RdM!=0 & RdM==Rs1E, select 10;
  - else if RegWriteW & RdW!=0 & RdW==Rs1E, select 01;
  - else select 00.
  - M takes priority over W.
- FSM states are IDLE, REQ and WAIT.
  - IDLE: dmem_req = MemReqM. If MemReqM & dmem_gnt, go to WAIT. If MemReqM & !dmem_gnt, go to REQ.
  - REQ: dmem_req = 1. On dmem_gnt, go to WAIT.
  - WAIT: dmem_req = 0. On dmem_rvalid, go to IDLE.
  - dmem_rvalid is ignored outside WAIT. Memory guarantees rvalid arrives no earlier than the cycle after gnt, so the minimum MEM occupancy is 2 cycles.
- memstall = MemReqM & !(state==WAIT & dmem_rvalid) & !MemErr. In the release cycle, MEM/WB captures ReadDataM and M advances, so the next instruction in M gets a fresh request.
- Timeout counter:
  - Increments every cycle in REQ or WAIT and clears in IDLE.
  - When it reaches TIMEOUT_CYCLES-1, MemErr pulses for 1 cycle, the FSM goes to IDLE, and the stall releases with undefined read data.
  - A late rvalid after a timeout is ignored.
- lwStall = (ResultSrcE==01) & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- Control priority:
  - If memstall: StallF=StallD=StallE=StallM=1 and FlushW=1. FlushD and FlushE are 0 (branch and load-use resolution are deferred until release).
  - Otherwise:
    - StallF = StallD = lwStall;
    - FlushE = lwStall | PCSrcE;
    - FlushD = PCSrcE;
    - StallE = StallM = FlushW = 0.
  - A simultaneous lwStall and PCSrcE gives both; the flush wins on ID/EX.
- Reset mid-access (REQ or WAIT): the FSM goes to IDLE immediately and dmem_req drops in the same cycle. The memory side must discard the in-flight access.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_t: FWD_RF=00, FWD_WB=01, FWD_MEM=10;
  - ResultSrc constants: RES_ALU=00, RES_MEM=01, RES_PC4=10;
  - mem_state_t: IDLE, REQ, WAIT.
- One sub-module, forward_unit, contains the purely combinational forwarding for both operands.
- The FSM, timeout counter and stall/flush priority logic stay in hazard_mem_ctrl.

Test Plan:
1. RdM=5 with RegWriteM=1 and RdW=5 with RegWriteW=1, Rs1E=5 -> ForwardAE=10. Then RdM=0 with RegWriteM=1 and Rs1E=0 -> ForwardAE=00.
2. Load in E with RdE=7, Rs2D=7, no memory access -> StallF=StallD=FlushE=1 for exactly 1 cycle, then 0.
3. MemReqM=1 with gnt in cycle 0 and rvalid in cycle 3 -> dmem_req high in cycle 0 only; Stall*=FlushW=1 in cycles 0-2; all 0 in cycle 3; state back to IDLE in cycle 4.
4. Gnt withheld for 2 cycles, then rvalid 1 cycle after gnt -> dmem_req high in cycles 0-2; stall held through cycle 2; stall released in cycle 3.
5. PCSrcE=1 during a memstall -> FlushD=FlushE=0 while stalled; FlushD=FlushE=1 in the release cycle.
6. TIMEOUT_CYCLES=8 with no rvalid -> MemErr pulses in cycle 7 and the stall releases; reset asserted mid-WAIT -> dmem_req=0 and all stalls 0 immediately.
